// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_pkg: shared definitions for the display scan controller slice.
//   scan_state_e : controller FSM state encoding
//   NUM_TAPS     : 3x3 neighbourhood taps fetched per pixel (fixed)
//   LAST_TAP     : index of the final tap
//   X_LAST       : last interior x coordinate (datapath/bench use)
//   Y_LAST       : last interior y coordinate (datapath/bench use)
//   tap_onehot() : tap index -> one-hot load strobe
package display_scan_pkg;

    localparam int unsigned NUM_TAPS = 9;
    localparam int unsigned LAST_TAP = 8;
    localparam int unsigned X_LAST   = 158;
    localparam int unsigned Y_LAST   = 118;

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StFetch,
        StPlot,
        StStepX,
        StCheckX,
        StStepY,
        StCheckY,
        StDone
    } scan_state_e;

    function automatic logic [NUM_TAPS-1:0] tap_onehot(input logic [3:0] idx);
        return NUM_TAPS'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: signals between the scan controller and the display datapath.
//   start/frame_sel/mode_sel : frame request from the top-level start logic
//   row_done/col_done        : registered end-of-row/column flags from the datapath
//   rowCountEn/colCountEn    : x/y advance pulses
//   reset_sig_x/reset_sig_y  : x/y counter clears
//   ld/sel_address           : tap load strobes and tap index for the address adaptor
//   sel_im/img_mode          : latched image select and processing mode
//   plot/busy/frame_done     : pixel write strobe, activity, frame completion pulse
// Modports: master = controller side, slave = datapath/start-logic side.
interface display_scan_ctrl_if;
    import display_scan_pkg::*;

    logic                start;
    logic [2:0]          frame_sel;
    logic [1:0]          mode_sel;
    logic                row_done;
    logic                col_done;
    logic                rowCountEn;
    logic                colCountEn;
    logic                reset_sig_x;
    logic                reset_sig_y;
    logic [NUM_TAPS-1:0] ld;
    logic [3:0]          sel_address;
    logic [2:0]          sel_im;
    logic [1:0]          img_mode;
    logic                plot;
    logic                busy;
    logic                frame_done;

    modport master (
        input  start, frame_sel, mode_sel, row_done, col_done,
        output rowCountEn, colCountEn, reset_sig_x, reset_sig_y, ld, sel_address,
               sel_im, img_mode, plot, busy, frame_done
    );

    modport slave (
        output start, frame_sel, mode_sel, row_done, col_done,
        input  rowCountEn, colCountEn, reset_sig_x, reset_sig_y, ld, sel_address,
               sel_im, img_mode, plot, busy, frame_done
    );

endinterface

// File: rtl/display_scan_ctrl_tap.sv
// tap_sequencer: walks the nine neighbourhood taps, holding each for RD_LAT+1 cycles.
//   clock, reset : clock, asynchronous active-high reset
//   run          : advance the sequence (controller is in FETCH)
//   clear        : return to tap 0, latency count 0
//   sel_address  : current tap index
//   ld           : one-hot load strobe, only on the last cycle of a tap
//   tap_last     : last cycle of the final tap
module tap_sequencer
    import display_scan_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                clear,
    output logic [3:0]          sel_address,
    output logic [NUM_TAPS-1:0] ld,
    output logic                tap_last
);

    localparam logic [1:0] LatMax  = 2'(RD_LAT);
    localparam logic [3:0] TapLast = 4'(LAST_TAP);

    logic [3:0] tap_q, tap_d;
    logic [1:0] lat_q, lat_d;
    logic       tap_end;

    // Memory data for the current tap is valid on the last latency cycle.
    assign tap_end = run && (lat_q == LatMax);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tap_q <= '0;
            lat_q <= '0;
        end else begin
            tap_q <= tap_d;
            lat_q <= lat_d;
        end
    end

    always_comb begin
        tap_d = tap_q;
        lat_d = lat_q;
        if (clear) begin
            tap_d = '0;
            lat_d = '0;
        end else if (run) begin
            if (lat_q == LatMax) begin
                lat_d = '0;
                // Wrap so the next pixel starts at tap 0 even without a clear.
                tap_d = (tap_q == TapLast) ? 4'd0 : tap_q + 4'd1;
            end else begin
                lat_d = lat_q + 2'd1;
            end
        end
    end

    assign sel_address = tap_q;
    assign ld          = tap_end ? tap_onehot(tap_q) : '0;
    assign tap_last    = tap_end && (tap_q == TapLast);

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: sequences the display datapath over every interior pixel of a frame.
// Per pixel: fetch 9 taps, pulse plot, advance x (and y at row end) using the
// datapath's registered row_done/col_done flags.
//   clock : system clock
//   reset : asynchronous active-high reset; abandons any frame in progress
//   bus   : display_scan_ctrl_if.master (request, datapath flags, control outputs)
// Build option: DISPLAY_SCAN_CTRL_CONTINUOUS_EN -- DONE loops back to CLR so frames scan
// back to back; a start seen in DONE re-latches frame_sel/mode_sel.
module display_scan_ctrl
    import display_scan_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    display_scan_ctrl_if.master bus
);

    scan_state_e         state_q, state_d;
    logic [2:0]          sel_im_q;
    logic [1:0]          img_mode_q;
    logic                latch_en;
    logic                run;
    logic                clear;
    logic                tap_last;
    logic [3:0]          sel_address;
    logic [NUM_TAPS-1:0] ld;

    assign run   = (state_q == StFetch);
    assign clear = (state_q == StClr) || (state_q == StCheckX) || (state_q == StCheckY);

    tap_sequencer #(
        .RD_LAT (RD_LAT)
    ) u_tap_sequencer (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .sel_address (sel_address),
        .ld          (ld),
        .tap_last    (tap_last)
    );

`ifdef DISPLAY_SCAN_CTRL_CONTINUOUS_EN
    assign latch_en = bus.start && ((state_q == StIdle) || (state_q == StDone));
`else
    assign latch_en = bus.start && (state_q == StIdle);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_im_q   <= '0;
            img_mode_q <= '0;
        end else if (latch_en) begin
            sel_im_q   <= bus.frame_sel;
            img_mode_q <= bus.mode_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.start) state_d = StClr;
            StClr:    state_d = StFetch;
            StFetch:  if (tap_last) state_d = StPlot;
            StPlot:   state_d = StStepX;
            StStepX:  state_d = StCheckX;
            // row_done was registered on the rowCountEn edge, so it is current here.
            StCheckX: state_d = bus.row_done ? StStepY : StFetch;
            StStepY:  state_d = StCheckY;
            StCheckY: state_d = bus.col_done ? StDone : StFetch;
`ifdef DISPLAY_SCAN_CTRL_CONTINUOUS_EN
            StDone:   state_d = StClr;
`else
            StDone:   state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rowCountEn  = 1'b0;
        bus.colCountEn  = 1'b0;
        bus.reset_sig_x = 1'b0;
        bus.reset_sig_y = 1'b0;
        bus.plot        = 1'b0;
        bus.frame_done  = 1'b0;
        bus.busy        = (state_q != StIdle);
        bus.ld          = ld;
        bus.sel_address = sel_address;
        bus.sel_im      = sel_im_q;
        bus.img_mode    = img_mode_q;
        unique case (state_q)
            StClr: begin
                bus.reset_sig_x = 1'b1;
                bus.reset_sig_y = 1'b1;
            end
            StPlot:  bus.plot       = 1'b1;
            StStepX: bus.rowCountEn = 1'b1;
            StStepY: bus.colCountEn = 1'b1;
            StDone:  bus.frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl. A behavioural datapath supplies row_done/col_done on a
// full-width frame of reduced height so whole frames fit in a short run.
module tb_display_scan_ctrl;
    import display_scan_pkg::*;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned Y_RUN      = 3;
    localparam int unsigned PIX_CYC    = 9 * (RD_LAT + 1) + 3;
    localparam int unsigned FIRST_PLOT = 9 * (RD_LAT + 1) + 2;
    localparam int unsigned FRAME_PIX  = X_LAST * Y_RUN;

    logic clock = 1'b0;
    logic reset = 1'b1;

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(
        .RD_LAT (RD_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {7'b0, dif.busy, dif.plot, dif.frame_done, dif.rowCountEn, dif.colCountEn,
                dif.reset_sig_x, dif.reset_sig_y, dif.ld, dif.sel_address, dif.sel_im,
                dif.img_mode};
    endfunction

    // Behavioural datapath: x in 1..X_LAST, y in 1..Y_RUN; flags registered on the advance.
    int unsigned x_pos, y_pos;
    logic        row_done_m, col_done_m;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            x_pos <= 0; y_pos <= 0; row_done_m <= 1'b0; col_done_m <= 1'b0;
        end else begin
            if (dif.reset_sig_x) begin
                x_pos <= 1; row_done_m <= 1'b0;
            end else if (dif.rowCountEn) begin
                row_done_m <= (x_pos == X_LAST);
                x_pos      <= (x_pos == X_LAST) ? 1 : x_pos + 1;
            end
            if (dif.reset_sig_y) begin
                y_pos <= 1; col_done_m <= 1'b0;
            end else if (dif.colCountEn) begin
                col_done_m <= (y_pos == Y_RUN);
                y_pos      <= (y_pos == Y_RUN) ? 1 : y_pos + 1;
            end
        end
    end

    assign dif.row_done = row_done_m;
    assign dif.col_done = col_done_m;

    // Monitor: counts events and accumulates protocol violations.
    int cyc = 0, plots = 0, col_ens = 0, frames = 0;
    int tap_err = 0, excl_err = 0, period_err = 0, busy_low = 0;
    int next_tap = 0, last_ld = 0, last_plot = 0;
    bit have_prev = 0, prev_row_end = 0, watch_busy = 0;

    always @(negedge clock) begin
        logic [8:0] ld_exp;
        cyc++;
        if (reset) begin
            next_tap  = 0;
            have_prev = 0;
        end else begin
            if (int'(dif.rowCountEn) + int'(dif.colCountEn) + int'(dif.reset_sig_x)
                + int'(dif.plot) > 1) excl_err++;
            if (watch_busy && !dif.busy) busy_low++;
            if (dif.reset_sig_x) begin
                have_prev = 0;
                next_tap  = 0;
            end
            if (dif.ld != '0) begin
                ld_exp = 9'b1 << next_tap;
                if (next_tap > 8 || dif.ld !== ld_exp || dif.sel_address != 4'(next_tap))
                    tap_err++;
                if (next_tap > 0 && cyc - last_ld != RD_LAT + 1) tap_err++;
                last_ld = cyc;
                next_tap++;
            end
            if (dif.plot) begin
                check("taps_per_pixel", next_tap, 9);
                next_tap = 0;
                if (have_prev && (cyc - last_plot != PIX_CYC + (prev_row_end ? 2 : 0)))
                    period_err++;
                have_prev    = 1;
                prev_row_end = (x_pos == X_LAST);
                last_plot    = cyc;
                plots++;
            end
            if (dif.colCountEn) col_ens++;
            if (dif.frame_done) frames++;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_plot(input string tag);
        int n = 0;
        while (!dif.plot && n < 200) begin step(); n++; end
        if (!dif.plot) check(tag, 0, 1);
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (!dif.frame_done && n < 20000) begin step(); n++; end
        if (!dif.frame_done) check(tag, 0, 1);
    endtask

    initial begin
        int clr_cyc, mark_plots, mark_frames, n;
        logic [2:0] fs;
        logic [1:0] ms;

        dif.start = 1'b0; dif.frame_sel = '0; dif.mode_sel = '0;
        reset = 1'b1;
        repeat (3) step();
        check("reset_outputs", outs_vec(), 0);
        reset = 1'b0;
        repeat ($urandom_range(1, 5)) step();
        check("idle_busy", dif.busy, 0);

        // Frame 1: frame_sel=3, mode_sel=2
        dif.frame_sel = 3'd3; dif.mode_sel = 2'd2; dif.start = 1'b1;
        step();
        dif.start = 1'b0; dif.frame_sel = 3'($urandom); dif.mode_sel = 2'($urandom);
        watch_busy = 1;
        clr_cyc = cyc;
        check("clr_reset_x", dif.reset_sig_x, 1);
        check("clr_reset_y", dif.reset_sig_y, 1);
        check("clr_sel_im", dif.sel_im, 3);
        check("clr_img_mode", dif.img_mode, 2);
        check("clr_busy", dif.busy, 1);
        step();
        check("clr_one_cycle", {dif.reset_sig_x, dif.reset_sig_y}, 0);
        check("fetch_tap0", dif.sel_address, 0);
        wait_plot("first_plot_timeout");
        check("first_plot_latency", cyc - clr_cyc + 1, FIRST_PLOT);

        // start while busy must be ignored
        repeat ($urandom_range(100, 2000)) step();
        dif.frame_sel = 3'd5; dif.mode_sel = 2'($urandom); dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        step();
        check("busy_start_sel_im", dif.sel_im, 3);
        check("busy_start_img_mode", dif.img_mode, 2);

        wait_frame_done("frame1_timeout");
        check("frame1_plots", plots, FRAME_PIX);
        check("frame1_col_ens", col_ens, Y_RUN);
        check("frame1_frames", frames, 1);
        check("done_busy", dif.busy, 1);
        check("done_sel_im", dif.sel_im, 3);
`ifdef DISPLAY_SCAN_CTRL_CONTINUOUS_EN
        // Re-latch in DONE; scanning continues into a second frame.
        mark_plots = plots;
        dif.frame_sel = 3'd3; dif.mode_sel = 2'd1; dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        check("cont_clr", dif.reset_sig_x, 1);
        check("cont_img_mode", dif.img_mode, 1);
        step();
        wait_frame_done("frame2_timeout");
        check("frame2_plots", plots - mark_plots, FRAME_PIX);
        check("frame2_frames", frames, 2);
        check("frame2_img_mode", dif.img_mode, 1);
        step();
        check("cont_busy_after_done", dif.busy, 1);
`else
        watch_busy = 0;
        step();
        check("idle_after_done", dif.busy, 0);
        repeat (5) step();
        check("single_frame_done", frames, 1);
`endif
        watch_busy = 0;
        check("busy_gaps", busy_low, 0);

        // Reset during FETCH tap 4
        fs = 3'($urandom); ms = 2'($urandom);
        dif.frame_sel = fs; dif.mode_sel = ms; dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        n = 0;
        while (dif.sel_address != 4'd4 && n < 200) begin step(); n++; end
        check("reach_tap4", dif.sel_address, 4);
        mark_frames = frames;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs_vec(), 0);
        step(); step();
        reset = 1'b0;
        step();
        check("abandoned_no_done", frames, mark_frames);
        check("abandoned_idle", dif.busy, 0);

        // Restart with random selects
        fs = 3'($urandom); ms = 2'($urandom);
        dif.frame_sel = fs; dif.mode_sel = ms; dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        mark_plots = plots;
        clr_cyc = cyc;
        check("restart_clr", dif.reset_sig_x, 1);
        check("restart_sel_im", dif.sel_im, 32'(fs));
        check("restart_img_mode", dif.img_mode, 32'(ms));
        step();
        wait_plot("restart_plot_timeout");
        check("restart_plot_latency", cyc - clr_cyc + 1, FIRST_PLOT);
        wait_frame_done("restart_frame_timeout");
        check("restart_plots", plots - mark_plots, FRAME_PIX);
        check("restart_frames", frames, mark_frames + 1);

        check("tap_errors", tap_err, 0);
        check("exclusive_errors", excl_err, 0);
        check("period_errors", period_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
